// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: word size, register count, NZP bit positions and
// the condition-code helper used by writeback and the branch unit.
package lc3_pkg;

    localparam int LC3_WORD_W = 16;
    localparam int LC3_NREG   = 8;

    // Bit positions inside the 3-bit {N,Z,P} condition-code vector
    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    // Exactly one bit of the result is set for any word
    function automatic logic [2:0] cc_from_word(input logic [LC3_WORD_W-1:0] word);
        logic [2:0] cc;
        cc       = '0;
        cc[CC_N] = word[LC3_WORD_W-1];
        cc[CC_Z] = (word == '0);
        cc[CC_P] = !word[LC3_WORD_W-1] && (word != '0);
        return cc;
    endfunction

endpackage

// File: rtl/lc3_sb_counter.sv
// One scoreboard entry: saturating up/down count of in-flight writes.
//   clk, rst   : clock, synchronous active-high reset
//   inc_i      : an instruction targeting this register was issued
//   dec_i      : a write to this register is retiring
//   flush_i    : clear the count (caller already masks inc/dec under flush)
//   cnt_o      : current in-flight count
//   err_o      : combinational, this cycle overflows or underflows the count
module lc3_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) err_o = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
        // inc and dec together: paired, count unchanged, never an error
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with write-to-read bypass, per-register pending-write
// scoreboard and NZP condition codes.
//   clk, rst               : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  : writeback port; wr_cc also updates nzp
//   rd1_*/rd2_*            : combinational read ports with busy (RAW) flags
//   issue_en/issue_dr      : decode issued a writer of issue_dr
//   issue_full             : issue_dr counter saturated, decode must stall
//   flush                  : squash all in-flight writes
//   nzp                    : registered {N,Z,P}
//   sb_err                 : sticky scoreboard overflow/underflow
module lc3_regfile_sb
    import lc3_pkg::*;
#(
    parameter  int DATA_W = LC3_WORD_W,
    parameter  int NREG   = LC3_NREG,
    parameter  int CNT_W  = 2,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_cc,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_busy,
    input  logic [AW-1:0]     rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd2_busy,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_dr,
    output logic              issue_full,
    input  logic              flush,
    output logic [2:0]        nzp,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [NREG-1:0]             cnt_err;
    logic [2:0]                  nzp_q, nzp_d;
    logic                        sb_err_q;

    // Scoreboard entries; flush masks the inc/dec strobes so a squashed
    // write neither decrements nor reports underflow.
    for (genvar i = 0; i < NREG; i++) begin : g_sb
        logic inc, dec;
        assign inc = issue_en && !flush && (issue_dr == AW'(i));
        assign dec = wr_en    && !flush && (wr_addr  == AW'(i));
        lc3_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (inc),
            .dec_i   (dec),
            .flush_i (flush),
            .cnt_o   (cnt[i]),
            .err_o   (cnt_err[i])
        );
    end

    // Generic-width NZP so DATA_W need not match the LC-3 word size
    always_comb begin
        nzp_d       = '0;
        nzp_d[CC_N] = wr_data[DATA_W-1];
        nzp_d[CC_Z] = (wr_data == '0);
        nzp_d[CC_P] = !wr_data[DATA_W-1] && (wr_data != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '0;
            nzp_q    <= 3'b010;
            sb_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
                if (wr_cc) nzp_q <= nzp_d;
            end
            sb_err_q <= sb_err_q | (|cnt_err);
        end
    end

    logic hit1, hit2;
    assign hit1 = BYPASS && wr_en && (wr_addr == rd1_addr);
    assign hit2 = BYPASS && wr_en && (wr_addr == rd2_addr);

    assign rd1_data = hit1 ? wr_data : regs_q[rd1_addr];
    assign rd2_data = hit2 ? wr_data : regs_q[rd2_addr];

    // The final outstanding write arriving this cycle is already bypassed
    assign rd1_busy = (cnt[rd1_addr] != '0) && !(hit1 && cnt[rd1_addr] == CNT_ONE);
    assign rd2_busy = (cnt[rd2_addr] != '0) && !(hit2 && cnt[rd2_addr] == CNT_ONE);

    assign issue_full = (cnt[issue_dr] == CNT_MAX);
    assign nzp        = nzp_q;
    assign sb_err     = sb_err_q;

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined LC-3, successor to the 8x16 two-read/one-write file.
- Adds synchronous reset, optional write-to-read bypass, and a per-register pending-write scoreboard so decode can detect RAW hazards.
- Adds an NZP condition-code register updated on writeback.
- Sits between decode (reads, issue) and writeback (write port).

Parameters:
- DATA_W, 16, register width in bits.
- NREG, 8, number of registers (power of two, >=2).
- AW, $clog2(NREG), register address width (derived, not overridden).
- CNT_W, 2, width of the per-register in-flight write counter (max 2^CNT_W-1 outstanding writes).
- BYPASS, 1, 1 = read of a register being written this cycle returns wr_data; 0 = returns the old value.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination register
- wr_data  in  DATA_W  writeback data
- wr_cc  in  1  with wr_en, update NZP from wr_data
- rd1_addr  in  AW  read port 1 address (SR1)
- rd1_data  out  DATA_W  read port 1 data, combinational
- rd1_busy  out  1  SR1 has an outstanding write
- rd2_addr  in  AW  read port 2 address (SR2)
- rd2_data  out  DATA_W  read port 2 data, combinational
- rd2_busy  out  1  SR2 has an outstanding write
- issue_en  in  1  decode issued an instruction that will write issue_dr
- issue_dr  in  AW  destination register of the issued instruction
- issue_full  out  1  counter of issue_dr is at maximum; decode must stall
- flush  in  1  squash all in-flight writes
- nzp  out  3  condition codes {N,Z,P}, registered
- sb_err  out  1  sticky scoreboard underflow/overflow error

Behaviour:
- Reset (rst=1 at posedge):
  - all registers become 0 and all counters become 0;
  - nzp becomes 3'b010 and sb_err becomes 0;
  - writes, issues and flush in the same cycle are ignored;
  - reset overrides everything, including mid-flight state.
- Write:
  - at the posedge with wr_en=1, R[wr_addr] <= wr_data.
  - If wr_cc is also 1, nzp <= {msb, data==0, !msb && data!=0}.
  - Writes are never blocked by flush.
- Reads:
  - rdX_data = R[rdX_addr], combinational, with zero latency.
  - If BYPASS=1 and wr_en=1 and wr_addr==rdX_addr, rdX_data = wr_data.
  - Both ports may read the same register.
- Counters, one per register, each CNT_W bits:
  - issue_en only: cnt[issue_dr] +1.
  - wr_en only: cnt[wr_addr] -1.
  - Both to the same register: unchanged.
  - Both to different registers: each updated.
- Busy:
  - rdX_busy = cnt[rdX_addr]!=0.
  - If BYPASS=1, rdX_busy is forced 0 when wr_en=1, wr_addr==rdX_addr and cnt==1 (the final write is arriving now).
- issue_full = (cnt[issue_dr]==max), combinational.
  - issue_en while full: counter saturates and sb_err sets.
- Write with cnt==0 (underflow): the data write still occurs, the counter stays 0 and sb_err sets.
  - Exception: no error if issue_en targets the same register in the same cycle (net 0 → stays 0, treat as paired).
- flush=1:
  - all counters <= 0 and issue_en in the same cycle is ignored;
  - a concurrent write updates data/nzp but does not decrement or flag underflow.
- sb_err clears only on rst.
- No state machine beyond the counters.
- All outputs other than nzp and sb_err are combinational from state and inputs.

Decomposition:
- Shared package lc3_pkg holds:
  - LC3_WORD_W=16 and LC3_NREG=8;
  - the nzp bit indices CC_N=2, CC_Z=1, CC_P=0;
  - a function cc_from_word(word) returning NZP, reused by the branch unit.
- Natural sub-module: lc3_sb_counter, one saturating up/down counter with an error flag, instantiated NREG times under generate.
- Data array and read muxes stay in the top module.

Test Plan:
- Reset then read all 8 registers → every rdX_data=0x0000, nzp=3'b010, busy=0, sb_err=0.
- Write R3=0x8001 with wr_cc, then read R3 on both ports → 0x8001 on both; nzp=3'b100. Then write R3=0x0000 with wr_cc → nzp=3'b010.
- BYPASS=1, same-cycle wr_en R5=0x1234 with rd1_addr=5 (old value 0x0000) → rd1_data=0x1234 that cycle. Repeat with BYPASS=0 → 0x0000, then 0x1234 next cycle.
- Scoreboard on R2:
  - issue R2 twice → rd1_busy=1 with cnt=2; first write → still busy;
  - second write with rd1_addr=2 → rd1_busy=0 in that cycle (BYPASS=1);
  - simultaneous issue+write of R2 at cnt=1 → cnt stays 1.
- Saturation/error:
  - issue R7 three times → issue_full=1; a fourth issue → sb_err=1, cnt stays 3;
  - after a new rst, a write to R4 with cnt=0 → R4 updated, sb_err=1.
- Flush: issue R1 and R6, then flush together with issue R0 and write R1=0x00FF → all busy=0, cnt[R0]=0, R1=0x00FF, no sb_err.
